ward_call_scheduler: RTL and testbench

WARD_CALL_SCHEDULER -- requirements
Module: ward_call_scheduler

---
 rtl/ward_pkg.sv | 15 +
 rtl/ward_prio_sel.sv | 23 ++
 rtl/ward_call_scheduler.sv | 100 ++++++++++
 tb/tb_ward_call_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ward_pkg.sv
// Shared types and constants for the ward call scheduler.
// FSM encoding, bed count, and the "no bed" marker.
package ward_pkg;

    localparam int NBEDS = 4;
    localparam int ACK_TIMEOUT_DEF = 16;
    localparam logic [2:0] NONE = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ALERT = 2'b01,
        S_SERVE = 2'b10
    } state_t;

endpackage

// File: rtl/ward_prio_sel.sv
// Strict-priority bed picker over the pending vector.
// dir=0 favours bed 0, dir=1 favours bed 3; NONE when empty.
import ward_pkg::*;

module ward_prio_sel (
    input  logic [NBEDS-1:0] pending,
    input  logic             dir,
    output logic [2:0]       index
);

    // Later loop hits overwrite earlier ones, so scan from lowest priority.
    always_comb begin
        index = NONE;
        if (!dir) begin
            for (int i = NBEDS - 1; i >= 0; i--)
                if (pending[i]) index = 3'(i);
        end else begin
            for (int i = 0; i < NBEDS; i++)
                if (pending[i]) index = 3'(i);
        end
    end

endmodule

// File: rtl/ward_call_scheduler.sv
// Nurse-call scheduler: latches bed calls, grants one at a time,
// and raises an alarm when the nurse is slow to accept.
import ward_pkg::*;

module ward_call_scheduler #(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBEDS-1:0] req,
    input  logic             dir,
    input  logic             ack,
    input  logic             done,
    output logic [2:0]       serving,
    output logic [NBEDS-1:0] pending,
    output logic             busy,
    output logic             alarm
);

    localparam logic [7:0] LIM = 8'(ACK_TIMEOUT - 1);

    state_t           state;
    state_t           state_n;
    logic [2:0]       sel;
    logic [7:0]       cnt;
    logic [7:0]       cnt_inc;
    logic [NBEDS-1:0] clr;

    ward_prio_sel u_sel (
        .pending (pending),
        .dir     (dir),
        .index   (sel)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (|pending) state_n = S_ALERT;
            S_ALERT: if (ack)      state_n = S_SERVE;
            S_SERVE: if (done)     state_n = S_IDLE;
            default:               state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // Served bed's call is retired on done; a same-cycle req re-sets it.
    always_comb begin
        clr = '0;
        if (state == S_SERVE && done && serving != NONE)
            clr[serving[1:0]] = 1'b1;
    end

    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            serving <= NONE;
            cnt     <= '0;
            alarm   <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | req;
            unique case (state)
                S_IDLE: begin
                    serving <= sel;
                    cnt     <= '0;
                    alarm   <= 1'b0;
                end
                S_ALERT: begin
                    if (ack) begin
                        cnt   <= '0;
                        alarm <= 1'b0;
                    end else begin
                        cnt   <= cnt_inc;
                        alarm <= alarm | (cnt_inc >= LIM);
                    end
                end
                S_SERVE: begin
                    if (done) serving <= NONE;
                    cnt   <= '0;
                    alarm <= 1'b0;
                end
                default: begin
                    serving <= NONE;
                    cnt     <= '0;
                    alarm   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ward_call_scheduler.sv
// Scoreboard bench for ward_call_scheduler: directed scenarios
// followed by random traffic against a behavioural model.
module tb_ward_call_scheduler;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       dir = 1'b0;
    logic       ack = 1'b0;
    logic       done = 1'b0;
    logic [2:0] serving;
    logic [3:0] pending;
    logic       busy;
    logic       alarm;

    ward_call_scheduler #(.ACK_TIMEOUT(T)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .dir     (dir),
        .ack     (ack),
        .done    (done),
        .serving (serving),
        .pending (pending),
        .busy    (busy),
        .alarm   (alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] s;
        logic [3:0] p;
        logic       b;
        logic       a;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    // Model: which bed is granted (-1 none), whether accepted,
    // outstanding calls, cycles waited for accept, alarm flag.
    int       m_bed = -1;
    bit       m_acked = 0;
    bit [3:0] m_pend = '0;
    int       m_wait = 0;
    bit       m_alarm = 0;

    function automatic int pick(bit [3:0] p, bit d);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = d ? 3 - i : i;
            if (p[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit [3:0] rq,
                              input bit d, input bit a, input bit dn);
        bit [3:0] np;
        if (r) begin
            m_bed = -1; m_acked = 0; m_pend = '0;
            m_wait = 0; m_alarm = 0;
            return;
        end
        np = m_pend | rq;
        if (m_bed < 0) begin
            m_bed = pick(m_pend, d);
            m_acked = 0; m_wait = 0; m_alarm = 0;
        end else if (!m_acked) begin
            if (a) begin
                m_acked = 1; m_wait = 0; m_alarm = 0;
            end else begin
                m_wait = (m_wait < 255) ? m_wait + 1 : 255;
                if (m_wait >= T - 1) m_alarm = 1;
            end
        end else if (dn) begin
            if (!rq[m_bed]) np[m_bed] = 1'b0;
            m_bed = -1;
            m_acked = 0;
        end
        m_pend = np;
    endtask

    task automatic cyc(input bit r, input bit [3:0] rq, input bit d,
                       input bit a, input bit dn);
        exp_t x;
        rst = r; req = rq; dir = d; ack = a; done = dn;
        @(posedge clk);
        model_step(r, rq, d, a, dn);
        x.s = (m_bed < 0) ? 3'b100 : 3'(m_bed);
        x.p = m_pend;
        x.b = (m_bed >= 0);
        x.a = m_alarm;
        q.push_back(x);
        #1;
    endtask

    task automatic idle(input int n, input bit d);
        for (int i = 0; i < n; i++) cyc(0, 4'b0000, d, 0, 0);
    endtask

    task automatic chk(input string n, input logic [7:0] act,
                       input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     n, act, expv, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("serving", 8'(serving), 8'(e.s));
                chk("pending", 8'(pending), 8'(e.p));
                chk("busy", 8'(busy), 8'(e.b));
                chk("alarm", 8'(alarm), 8'(e.a));
            end
        end
    end

    initial begin
        cyc(1, 4'b0000, 0, 0, 0);
        cyc(1, 4'b1111, 0, 1, 1);
        // two-bed call, bed 0 favoured
        cyc(0, 4'b0110, 0, 0, 0);
        idle(3, 0);
        cyc(0, 4'b0000, 0, 1, 0);
        cyc(0, 4'b0000, 0, 0, 1);
        idle(3, 0);
        // same call, bed 3 favoured, then finish and regrant
        cyc(1, 4'b0000, 1, 0, 0);
        cyc(0, 4'b0110, 1, 0, 0);
        idle(2, 1);
        cyc(0, 4'b0000, 1, 1, 0);
        idle(1, 1);
        cyc(0, 4'b0000, 1, 0, 1);
        idle(3, 1);
        // timeout alarm, then accept
        cyc(1, 4'b0000, 0, 0, 0);
        cyc(0, 4'b0001, 0, 0, 0);
        idle(20, 0);
        cyc(0, 4'b0000, 0, 1, 1);
        idle(2, 0);
        cyc(0, 4'b0000, 0, 0, 1);
        idle(2, 0);
        // dir and new call during service do not disturb grant
        cyc(1, 4'b0000, 0, 0, 0);
        cyc(0, 4'b0100, 0, 0, 0);
        idle(2, 0);
        cyc(0, 4'b0000, 1, 1, 0);
        cyc(0, 4'b0001, 0, 0, 0);
        cyc(0, 4'b0000, 1, 0, 0);
        cyc(0, 4'b0000, 1, 0, 1);
        idle(3, 1);
        // done with same-bed request keeps the call
        cyc(1, 4'b0000, 0, 0, 0);
        cyc(0, 4'b0100, 0, 0, 0);
        idle(2, 0);
        cyc(0, 4'b0000, 0, 1, 0);
        cyc(0, 4'b0100, 0, 0, 1);
        idle(3, 0);
        // reset in service, stray pulses afterwards
        cyc(1, 4'b0000, 0, 0, 0);
        cyc(0, 4'b1011, 0, 0, 0);
        idle(2, 0);
        cyc(0, 4'b0000, 0, 1, 0);
        idle(1, 0);
        cyc(1, 4'b0000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 1, 0);
        cyc(0, 4'b0000, 0, 0, 1);
        idle(2, 0);
        // counter saturation on a very long wait
        cyc(0, 4'b1000, 0, 0, 0);
        idle(300, 0);
        cyc(0, 4'b0000, 0, 1, 0);
        cyc(0, 4'b0000, 0, 0, 1);
        idle(2, 0);
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            bit       r, d, a, dn;
            bit [3:0] rq;
            r  = ($urandom_range(0, 199) == 0);
            rq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            d  = 1'($urandom);
            a  = ($urandom_range(0, 24) == 0);
            dn = ($urandom_range(0, 5) == 0);
            cyc(r, rq, d, a, dn);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expected 0 entries", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
